// File: rtl/cp0_if.sv
// cp0_if: CP0 bus (mtc0/mfc0, exception inputs, register outputs); slave = regfile, master = core
interface cp0_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;
  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );
  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i, bad_addr_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o, timer_int_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 registers (BadVAddr/Count/Compare/Status/Cause/EPC), exception commit, timer; ports clk, resetn (sync, low), bus (cp0_if.slave)
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input logic   clk,
  input logic   resetn,
  cp0_if.slave  bus
);
  localparam logic [4:0] A_BADV = 5'd8, A_COUNT = 5'd9, A_CMP = 5'd11,
                         A_STATUS = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  logic [31:0] count, compare, status, cause, epc, badvaddr;
  logic        timer_int, phase, exc, eret, wr;
  logic [4:0]  code;
  always_comb begin
    exc  = bus.excepttype_i inside {32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c};
    eret = bus.excepttype_i == 32'h0e;
    wr   = bus.we_i & ~exc & ~eret;
    code = bus.excepttype_i == 32'h01 ? 5'h00 : bus.excepttype_i[4:0];
    bus.data_o = bus.raddr_i == A_BADV   ? badvaddr :
                 bus.raddr_i == A_COUNT  ? count    :
                 bus.raddr_i == A_CMP    ? compare  :
                 bus.raddr_i == A_STATUS ? status   :
                 bus.raddr_i == A_CAUSE  ? cause    :
                 bus.raddr_i == A_EPC    ? epc      : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count     <= '0;
      compare   <= '0;
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
      badvaddr  <= '0;
      timer_int <= 1'b0;
      phase     <= 1'b0;
    end else begin
      phase        <= ~phase;
      count        <= wr && bus.waddr_i == A_COUNT ? bus.data_i : count + {31'b0, phase};
      cause[15:10] <= {bus.int_i[5] | timer_int, bus.int_i[4:0]};
      if (wr && bus.waddr_i == A_CMP) begin
        compare   <= bus.data_i;
        timer_int <= 1'b0;
      end else if (count == compare && |compare)
        timer_int <= 1'b1;
      if (wr && bus.waddr_i == A_STATUS)
        status <= (status & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
      if (wr && bus.waddr_i == A_CAUSE)
        cause[9:8] <= bus.data_i[9:8];
      if (wr && bus.waddr_i == A_EPC)
        epc <= bus.data_i;
      if (exc) begin
        cause[6:2] <= code;
        status[1]  <= 1'b1;
        if (!status[1]) begin
          epc       <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4 : bus.current_inst_addr_i;
          cause[31] <= bus.is_in_delayslot_i;
        end
        if (bus.excepttype_i == 32'h04 || bus.excepttype_i == 32'h05)
          badvaddr <= bus.bad_addr_i;
      end
      if (eret)
        status[1] <= 1'b0;
    end
  end
  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.badvaddr_o  = badvaddr;
  assign bus.timer_int_o = timer_int;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed self-checking bench for cp0_regfile
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;
  cp0_if bus();
  cp0_regfile dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1;
    bus.waddr_i = a;
    bus.data_i = d;
    tick(1);
    bus.we_i = 1'b0;
  endtask
  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] bad);
    bus.excepttype_i = t;
    bus.current_inst_addr_i = pc;
    bus.is_in_delayslot_i = ds;
    bus.bad_addr_i = bad;
    tick(1);
    bus.excepttype_i = '0;
  endtask
  initial begin
    resetn = 1'b0;
    bus.we_i = 1'b0;
    bus.waddr_i = '0;
    bus.raddr_i = '0;
    bus.data_i = '0;
    bus.int_i = '0;
    bus.excepttype_i = '0;
    bus.current_inst_addr_i = '0;
    bus.is_in_delayslot_i = 1'b0;
    bus.bad_addr_i = '0;
    tick(2);
    chk("rst_status", bus.status_o, 32'h0040_0000);
    chk("rst_count", bus.count_o, 32'h0);
    chk("rst_cause", bus.cause_o, 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_badv", bus.badvaddr_o, 32'h0);
    chk("rst_cmp", bus.compare_o, 32'h0);
    chk("rst_timer", {31'b0, bus.timer_int_o}, 32'h0);
    resetn = 1'b1;
    tick(2);
    chk("count_first", bus.count_o, 32'h1);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    chk("count_load", bus.count_o, 32'h0);
    tick(10);
    chk("count_5", bus.count_o, 32'd5);
    chk("timer_before", {31'b0, bus.timer_int_o}, 32'h0);
    tick(1);
    chk("timer_set", {31'b0, bus.timer_int_o}, 32'h1);
    tick(1);
    chk("cause_ip7", bus.cause_o, 32'h0000_8000);
    mtc0(5'd11, 32'h20);
    chk("timer_clr", {31'b0, bus.timer_int_o}, 32'h0);
    chk("cmp_new", bus.compare_o, 32'h20);
    bus.raddr_i = 5'd11;
    #1 chk("mfc0_cmp", bus.data_o, 32'h20);
    exc(32'h0c, 32'hbfc0_0104, 1'b1, 32'h0);
    chk("ds_epc", bus.epc_o, 32'hbfc0_0100);
    chk("ds_bd", {31'b0, bus.cause_o[31]}, 32'h1);
    chk("ds_code", {27'b0, bus.cause_o[6:2]}, 32'h0c);
    chk("ds_status", bus.status_o, 32'h0040_0002);
    exc(32'h04, 32'h8000_1000, 1'b0, 32'h8000_2003);
    chk("nest_epc", bus.epc_o, 32'hbfc0_0100);
    chk("nest_bd", {31'b0, bus.cause_o[31]}, 32'h1);
    chk("nest_code", {27'b0, bus.cause_o[6:2]}, 32'h04);
    chk("nest_badv", bus.badvaddr_o, 32'h8000_2003);
    mtc0(5'd12, 32'h0040_0003);
    chk("status_wr", bus.status_o, 32'h0040_0003);
    exc(32'h0e, 32'h0, 1'b0, 32'h0);
    chk("eret_status", bus.status_o, 32'h0040_0001);
    chk("eret_epc", bus.epc_o, 32'hbfc0_0100);
    bus.we_i = 1'b1;
    bus.waddr_i = 5'd14;
    bus.data_i = 32'h1234;
    exc(32'h08, 32'h8000_0010, 1'b0, 32'h0);
    bus.we_i = 1'b0;
    chk("col_epc", bus.epc_o, 32'h8000_0010);
    chk("col_bd", {31'b0, bus.cause_o[31]}, 32'h0);
    chk("col_status", bus.status_o, 32'h0040_0003);
    bus.we_i = 1'b1;
    bus.waddr_i = 5'd14;
    bus.data_i = 32'h55;
    exc(32'h02, 32'h0, 1'b0, 32'h0);
    bus.we_i = 1'b0;
    chk("ign_epc", bus.epc_o, 32'h55);
    chk("ign_status", bus.status_o, 32'h0040_0003);
    mtc0(5'd12, 32'hffff_ffff);
    chk("status_mask", bus.status_o, 32'h0040_ff03);
    mtc0(5'd13, 32'hffff_ffff);
    chk("cause_mask", bus.cause_o, 32'h0000_0320);
    mtc0(5'd8, 32'h0);
    chk("badv_ro", bus.badvaddr_o, 32'h8000_2003);
    bus.int_i = 6'b100001;
    tick(1);
    chk("cause_int", bus.cause_o, 32'h0000_8720);
    bus.raddr_i = 5'd7;
    #1 chk("mfc0_7", bus.data_o, 32'h0);
    bus.raddr_i = 5'd8;
    #1 chk("mfc0_badv", bus.data_o, 32'h8000_2003);
    bus.raddr_i = 5'd12;
    #1 chk("mfc0_status", bus.data_o, 32'h0040_ff03);
    mtc0(5'd9, 32'hffff_ffff);
    chk("count_max", bus.count_o, 32'hffff_ffff);
    tick(2);
    chk("count_wrap", bus.count_o, 32'h0);
    resetn = 1'b0;
    bus.we_i = 1'b1;
    bus.waddr_i = 5'd14;
    bus.data_i = 32'hdead;
    exc(32'h0c, 32'h8000_0000, 1'b1, 32'h0);
    bus.we_i = 1'b0;
    chk("rw_epc", bus.epc_o, 32'h0);
    chk("rw_status", bus.status_o, 32'h0040_0000);
    chk("rw_cause", bus.cause_o, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file for the MIPS core, sitting beside the memory stage.
- Consumes the exception type, PC and delay-slot flag produced by the memory-stage exception decoder.
- Commits exception state (EPC, Cause, Status.EXL, BadVAddr) and services mtc0 writes and mfc0 reads.
- Supplies Status/Cause/EPC back to the decoder and owns the Count/Compare timer interrupt.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, EXL=0, IE=0)
- EXC_VECTOR_UNUSED, none, no parameters beyond STATUS_RST; addresses are fixed CP0 numbers

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 destination register number
- raddr_i  in  5  mfc0 source register number
- data_i  in  32  mtc0 write data
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  exception code word from the decoder (0 = none)
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot
- bad_addr_i  in  32  faulting virtual address (instruction or data)
- data_o  out  32  mfc0 read data (combinational)
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  current register values
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14.
- data_o is a combinational mux on raddr_i over the current registered values; any other address returns 0.
- No write-to-read bypass inside the block.
- Reset (resetn=0 at a clk edge):
  - all registers 0 except Status=STATUS_RST
  - timer_int_o=0; the tick phase bit is cleared
- Reset wins over every other event.
- Count:
  - a phase bit toggles every cycle; Count increments (wraps at 2^32) on cycles where the phase is 1, i.e. every 2 clocks
  - an mtc0 to Count loads data_i and overrides that cycle's increment; the phase is unaffected
- Timer:
  - timer_int_o is set to 1 on the cycle after Count==Compare with Compare!=0
  - it stays 1 until an mtc0 to Compare, which loads Compare and clears timer_int_o
  - a Compare write in the same cycle as a match takes precedence (result: cleared)
- Cause.IP is refreshed every cycle: Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]}.
- Writable fields on mtc0:
  - Status: IM[15:8], EXL[1], IE[0]; all other Status bits hold
  - Cause: IP[9:8] only
  - EPC, Compare, Count: full 32 bits
  - BadVAddr: read-only; writes are ignored
- Exception commit applies when excepttype_i is one of 0x01, 0x04, 0x05, 0x08, 0x09, 0x0a, 0x0c:
  - Cause.ExcCode[6:2] <= code: int=0x00, adel=0x04, ades=0x05, sys=0x08, bp=0x09, ri=0x0a, ov=0x0c
  - only if Status.EXL==0: EPC <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i, and Cause.BD[31] <= is_in_delayslot_i
  - if EXL is already 1, EPC and BD hold
  - Status.EXL <= 1
  - for 0x04 and 0x05 only: BadVAddr <= bad_addr_i
- eret (excepttype_i==0x0e): Status.EXL <= 0; nothing else changes.
- Any other nonzero excepttype_i is ignored.
- Simultaneous mtc0 and exception/eret in the same cycle:
  - the exception/eret update wins for the fields it touches
  - the mtc0 write is dropped entirely, because the instruction is flushed
- Cause.IP refresh still occurs in exception cycles. Count increment continues regardless of exceptions.
- Latency: all register updates are visible on the outputs one cycle after the triggering edge.

Test Plan:
- Reset: hold resetn=0 for 2 cycles, then release -> status_o=0x00400000, all other outputs 0, timer_int_o=0; Count reads 1 after 2 more cycles.
- Timer:
  - mtc0 Compare=5, then mtc0 Count=0 -> Count reaches 5 after 10 clocks and timer_int_o=1 the next cycle, with cause_o[15]=1
  - mtc0 Compare=0x20 -> timer_int_o=0 next cycle
- Exception in delay slot: excepttype_i=0x0c, pc=0xbfc00104, delayslot=1, EXL=0 -> epc_o=0xbfc00100, cause_o[31]=1, cause_o[6:2]=0x0c, status_o[1]=1.
- Nested exception: with EXL=1, excepttype_i=0x04, pc=0x80001000, bad_addr_i=0x80002003 -> EPC/BD unchanged, ExcCode=0x04, badvaddr_o=0x80002003.
- eret: excepttype_i=0x0e with status_o=0x00400003 -> status_o=0x00400001, EPC unchanged.
- Collision and masks:
  - mtc0 EPC=0x1234 in the same cycle as excepttype_i=0x08, pc=0x80000010, EXL=0 -> epc_o=0x80000010
  - mtc0 Status=0xFFFFFFFF -> status_o=0x0040FF03
  - mfc0 raddr=7 -> 0
